add_nib_seq: RTL and testbench
==============================

# add_nib_seq

Sequential wide adder/subtractor built around one 4-bit carry-lookahead adder slice (fa_4bit). It accepts a WIDTH-bit operand pair over a valid/ready handshake, passes the operands through the shared nibble slice one nibble per cycle (LSB first), and carries between nibbles in a register. It presents the registered result with carry-out and signed overflow on a second valid/ready handshake. It is the area-optimised alternative to a full-width adder for non-critical arithmetic paths.

## Interface

- WIDTH, 16, operand/result width; multiple of 4, minimum 8; NIB = WIDTH/4 processing cycles.
- i_clk  input  1  clock; all state updates on rising edge.
- i_rst  input  1  synchronous, active-high reset.
- i_valid  input  1  operand request valid.
- o_ready  output  1  block can accept operands.
- i_a  input  WIDTH  operand A.
- i_b  input  WIDTH  operand B.
- i_cin  input  1  carry-in for add; ignored when i_sub=1.
- i_sub  input  1  1 = A - B, 0 = A + B + i_cin.
- o_valid  output  1  result valid.
- i_ready  input  1  downstream accepts result.
- o_s  output  WIDTH  sum/difference.
- o_c  output  1  carry-out of bit WIDTH-1; for subtract, 1 = no borrow (A >= B unsigned).
- o_ovf  output  1  two's-complement overflow.

## Operation

- One clock, i_clk. Reset is synchronous and active-high on i_rst.
- States: IDLE, RUN, DONE. Reset state is IDLE.
- IDLE: o_ready=1. When i_valid=1, operands are accepted on that edge:
  - i_a and i_b (B inverted when i_sub=1) latch into internal shift registers.
  - The carry register loads i_sub ? 1 : i_cin.
  - The nibble counter clears to 0 and the state goes to RUN.
- RUN: o_ready=0. Each cycle the slice adds the low nibble of the A/B registers and the carry register.
  - On the edge, the sum nibble is written to result bits [4k+3:4k] (k = counter) and the carry register takes the slice carry-out.
  - The A/B registers shift right by 4 and the counter increments.
  - When k = NIB-1, the state goes to DONE on the same edge, and o_c and o_ovf are captured then.
- o_ovf = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1. Carry-in to the MSB is computed as a[W-1] ^ b'[W-1] ^ s[W-1], where b' is the possibly inverted B. Arithmetic is modulo 2^WIDTH.
- DONE: o_valid=1. o_s, o_c and o_ovf are held stable until i_ready=1; then the state goes to IDLE on that edge. i_valid is ignored and o_ready=0.
- o_ready is high only in IDLE. There is no accept in the same cycle as result hand-off.
- Reset values: o_ready=1 after the reset edge (IDLE), o_valid=0, o_s=0, o_c=0, o_ovf=0. The counter, carry and operand registers are also cleared to 0.
- Reset in RUN or DONE aborts the operation and discards partial and pending results. No o_valid pulse follows.
- Inputs i_a, i_b, i_cin and i_sub are sampled only at the accept edge. Changes afterwards have no effect.
- o_s, o_c and o_ovf update only on the RUN→DONE edge (partial writes go to an internal register). Outputs are not glitched during RUN; they hold the previous result until the new one is valid.

## Timing

- Accept at edge E0 (IDLE, i_valid=1).
- RUN cycles follow E0 for nibbles 0..NIB-1.
- o_valid rises after edge E0+NIB. For WIDTH=16 this is 4 cycles after the accept edge.
- With i_ready=1 held high, the DONE→IDLE edge is E0+NIB+1 and the next accept can be at E0+NIB+2. Throughput is one operation per NIB+2 cycles.
- Each additional cycle with i_ready=0 in DONE adds one cycle of latency to the next accept.
- Combinational path per cycle: one 4-bit CLA slice plus the carry mux. No path spans WIDTH.

## Test plan

All scenarios use WIDTH=16.

- Add with wrap: A=0xFFFF, B=0x0001, i_cin=0, i_sub=0 → o_s=0x0000, o_c=1, o_ovf=0. o_valid is first high exactly 4 cycles after the accept edge.
- Signed overflow: A=0x7FFF, B=0x0001, cin=0 → o_s=0x8000, o_c=0, o_ovf=1.
- Add with carry-in through all nibbles: A=0x0FFF, B=0x0000, cin=1 → o_s=0x1000, o_c=0, o_ovf=0.
- Subtract with borrow: A=0x0005, B=0x0007, i_sub=1, i_cin=1 (ignored) → o_s=0xFFFE, o_c=0, o_ovf=0. Also A=0x8000, B=0x0001, i_sub=1 → o_s=0x7FFF, o_c=1, o_ovf=1.
- Backpressure: hold i_ready=0 for 3 cycles in DONE, with i_valid=1 and changing operands. Required:
  - o_s, o_c and o_ovf stay stable; o_valid=1; o_ready=0.
  - After i_ready=1, o_valid drops next cycle, o_ready=1, and the new operands are accepted the following edge.
- Reset mid-operation: assert i_rst during RUN at nibble 2 → next cycle o_ready=1, o_valid=0, o_s=0, o_c=0, o_ovf=0. No result appears for the aborted request, and a subsequent request completes correctly with 4-cycle latency.

Source files
------------

// File: rtl/add_nib_seq_if.sv
// Handshake and data bundle for the nibble-serial adder/subtractor.
// The slave side is the adder. The master side is whoever supplies
// the operands and takes the result.
interface add_nib_seq_if #(
  parameter int WIDTH = 16
);

  logic             i_valid;
  logic             o_ready;
  logic [WIDTH-1:0] i_a;
  logic [WIDTH-1:0] i_b;
  logic             i_cin;
  logic             i_sub;
  logic             o_valid;
  logic             i_ready;
  logic [WIDTH-1:0] o_s;
  logic             o_c;
  logic             o_ovf;

  modport slave (
    input  i_valid,
    output o_ready,
    input  i_a,
    input  i_b,
    input  i_cin,
    input  i_sub,
    output o_valid,
    input  i_ready,
    output o_s,
    output o_c,
    output o_ovf
  );

  modport master (
    output i_valid,
    input  o_ready,
    output i_a,
    output i_b,
    output i_cin,
    output i_sub,
    input  o_valid,
    output i_ready,
    input  o_s,
    input  o_c,
    input  o_ovf
  );

endinterface

// File: rtl/add_nib_seq.sv
// Sequential WIDTH-bit adder/subtractor that reuses one 4-bit
// carry-lookahead slice. It processes one nibble per cycle, LSB first,
// and keeps the carry between nibbles in a register.

// 4-bit carry-lookahead adder slice.
module fa_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);

  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  assign g = a & b;
  assign p = a ^ b;

  // Each carry is expanded directly from generate/propagate terms, so no ripple chain.
  always_comb begin
    c[0] = cin;
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
         | (p[2] & p[1] & p[0] & cin);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
         | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & cin);
  end

  assign s    = p ^ c[3:0];
  assign cout = c[4];

endmodule

module add_nib_seq #(
  parameter int WIDTH = 16
) (
  input  logic          i_clk,
  input  logic          i_rst,
  add_nib_seq_if.slave  bus
);

  localparam int NIB = WIDTH / 4;
  localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  state_t           state_next;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic [WIDTH-5:0] res_acc;
  logic [WIDTH-1:0] res_cat;

  logic [WIDTH-1:0] s_q;
  logic             c_q;
  logic             ovf_q;

  logic [3:0]       nib_sum;
  logic             nib_cout;
  logic             last_nib;
  logic             msb_cin;
  logic             ovf_now;

  fa_4bit u_slice (
    .a    (a_sh[3:0]),
    .b    (b_sh[3:0]),
    .cin  (carry),
    .s    (nib_sum),
    .cout (nib_cout)
  );

  // New sum nibbles enter at the top and the earlier ones move down.
  // After the last nibble, res_cat is the complete result in order.
  assign res_cat  = {nib_sum, res_acc};
  assign last_nib = (state == RUN) && (cnt == CW'(NIB - 1));

  // On the last nibble, the slice's bit 3 is bit WIDTH-1 of the operands.
  // Recover the MSB carry-in from a ^ b' ^ s.
  assign msb_cin  = a_sh[3] ^ b_sh[3] ^ nib_sum[3];
  assign ovf_now  = msb_cin ^ nib_cout;

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: accept in IDLE, run NIB cycles, hold until the result is taken.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (bus.i_valid) begin
          state_next = RUN;
        end
      end
      RUN: begin
        if (last_nib) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (bus.i_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Operand shifters, inter-nibble carry, counter and partial result.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      a_sh    <= '0;
      b_sh    <= '0;
      carry   <= 1'b0;
      cnt     <= '0;
      res_acc <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.i_valid) begin
            a_sh    <= bus.i_a;
            b_sh    <= bus.i_sub ? ~bus.i_b : bus.i_b;
            carry   <= bus.i_sub ? 1'b1 : bus.i_cin;
            cnt     <= '0;
            res_acc <= '0;
          end
        end
        RUN: begin
          a_sh    <= {4'b0000, a_sh[WIDTH-1:4]};
          b_sh    <= {4'b0000, b_sh[WIDTH-1:4]};
          carry   <= nib_cout;
          cnt     <= cnt + CW'(1);
          res_acc <= res_cat[WIDTH-1:4];
        end
        default: begin
        end
      endcase
    end
  end

  // Visible result registers. They change only when the final nibble completes.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s_q   <= '0;
      c_q   <= 1'b0;
      ovf_q <= 1'b0;
    end else if (last_nib) begin
      s_q   <= res_cat;
      c_q   <= nib_cout;
      ovf_q <= ovf_now;
    end
  end

  assign bus.o_ready = (state == IDLE);
  assign bus.o_valid = (state == DONE);
  assign bus.o_s     = s_q;
  assign bus.o_c     = c_q;
  assign bus.o_ovf   = ovf_q;

endmodule

// File: tb/tb_add_nib_seq.sv
// Scoreboard bench for add_nib_seq at WIDTH=16.
// Expected results are queued at the accept edge and compared when o_valid rises.
module tb_add_nib_seq;

  localparam int WIDTH = 16;

  typedef struct packed {
    logic [15:0] s;
    logic        c;
    logic        ovf;
  } exp_t;

  logic clk;
  logic rst;

  add_nib_seq_if #(.WIDTH(WIDTH)) bus ();

  add_nib_seq #(.WIDTH(WIDTH)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  exp_t        sb[$];
  exp_t        last_exp;
  logic [15:0] prev_s;
  int          checks;
  int          errors;

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Stops the run if the flow gets stuck.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b,
                                 input logic cin, input logic sub);
    exp_t        r;
    logic [15:0] bp;
    logic [16:0] full;
    bp    = sub ? ~b : b;
    full  = {1'b0, a} + {1'b0, bp} + {16'd0, (sub ? 1'b1 : cin)};
    r.s   = full[15:0];
    r.c   = full[16];
    r.ovf = (a[15] == bp[15]) && (full[15] != a[15]);
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Called at a negedge while the DUT is in IDLE. Returns at the negedge after the accept.
  task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b,
                               input logic cin, input logic sub);
    checkOutput("ready_idle", {31'd0, bus.o_ready}, 32'd1);
    bus.i_valid = 1'b1;
    bus.i_a     = a;
    bus.i_b     = b;
    bus.i_cin   = cin;
    bus.i_sub   = sub;
    @(posedge clk);
    sb.push_back(model(a, b, cin, sub));
    @(negedge clk);
    bus.i_valid = 1'b0;
    bus.i_a     = 16'($urandom);
    bus.i_b     = 16'($urandom);
    bus.i_cin   = 1'($urandom);
    bus.i_sub   = 1'($urandom);
  endtask

  // Waits for o_valid, then checks latency, output hold during RUN, and the popped result.
  task automatic waitResult();
    int   lat;
    logic hold_ok;
    exp_t e;
    lat     = 0;
    hold_ok = 1'b1;
    while (!bus.o_valid && lat < 20) begin
      if (bus.o_s !== prev_s) hold_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
    checkOutput("latency", lat, 32'd4);
    checkOutput("hold_run", {31'd0, hold_ok}, 32'd1);
    if (sb.size() == 0) begin
      checkOutput("sb_nonempty", 32'd0, {31'd0, bus.o_valid});
    end else begin
      e = sb.pop_front();
      checkOutput("o_s",   {16'd0, bus.o_s},   {16'd0, e.s});
      checkOutput("o_c",   {31'd0, bus.o_c},   {31'd0, e.c});
      checkOutput("o_ovf", {31'd0, bus.o_ovf}, {31'd0, e.ovf});
      checkOutput("ready_done", {31'd0, bus.o_ready}, 32'd0);
      last_exp = e;
      prev_s   = e.s;
    end
  endtask

  task automatic handOff();
    bus.i_ready = 1'b1;
    @(negedge clk);
    checkOutput("valid_after_handoff", {31'd0, bus.o_valid}, 32'd0);
    checkOutput("ready_after_handoff", {31'd0, bus.o_ready}, 32'd1);
    bus.i_ready = 1'b0;
  endtask

  task automatic runOp(input logic [15:0] a, input logic [15:0] b,
                       input logic cin, input logic sub);
    applyStimulus(a, b, cin, sub);
    waitResult();
    handOff();
  endtask

  // Main sequence.
  initial begin
    logic saw_valid;
    checks      = 0;
    errors      = 0;
    prev_s      = 16'h0000;
    last_exp    = '0;
    rst         = 1'b1;
    bus.i_valid = 1'b0;
    bus.i_ready = 1'b0;
    bus.i_a     = 16'h0;
    bus.i_b     = 16'h0;
    bus.i_cin   = 1'b0;
    bus.i_sub   = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    checkOutput("rst_ready", {31'd0, bus.o_ready}, 32'd1);
    checkOutput("rst_valid", {31'd0, bus.o_valid}, 32'd0);
    checkOutput("rst_s",     {16'd0, bus.o_s},     32'd0);
    checkOutput("rst_c",     {31'd0, bus.o_c},     32'd0);
    checkOutput("rst_ovf",   {31'd0, bus.o_ovf},   32'd0);

    runOp(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    runOp(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    runOp(16'h0FFF, 16'h0000, 1'b1, 1'b0);
    runOp(16'h0005, 16'h0007, 1'b1, 1'b1);

    // Backpressure: the result must hold while new requests are offered and ignored.
    applyStimulus(16'h8000, 16'h0001, 1'b0, 1'b1);
    waitResult();
    for (int i = 0; i < 3; i++) begin
      bus.i_valid = 1'b1;
      bus.i_a     = 16'($urandom);
      bus.i_b     = 16'($urandom);
      bus.i_cin   = 1'($urandom);
      bus.i_sub   = 1'($urandom);
      @(negedge clk);
      checkOutput("bp_valid", {31'd0, bus.o_valid}, 32'd1);
      checkOutput("bp_ready", {31'd0, bus.o_ready}, 32'd0);
      checkOutput("bp_s",     {16'd0, bus.o_s},     {16'd0, last_exp.s});
      checkOutput("bp_c",     {31'd0, bus.o_c},     {31'd0, last_exp.c});
      checkOutput("bp_ovf",   {31'd0, bus.o_ovf},   {31'd0, last_exp.ovf});
    end
    bus.i_a     = 16'h1234;
    bus.i_b     = 16'h0FF0;
    bus.i_cin   = 1'b1;
    bus.i_sub   = 1'b0;
    bus.i_valid = 1'b1;
    bus.i_ready = 1'b1;
    @(negedge clk);
    checkOutput("bp_release_valid", {31'd0, bus.o_valid}, 32'd0);
    checkOutput("bp_release_ready", {31'd0, bus.o_ready}, 32'd1);
    bus.i_ready = 1'b0;
    @(posedge clk);
    sb.push_back(model(16'h1234, 16'h0FF0, 1'b1, 1'b0));
    @(negedge clk);
    bus.i_valid = 1'b0;
    waitResult();
    handOff();

    // Reset during RUN at nibble 2 discards the request.
    applyStimulus(16'h1111, 16'h2222, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("abort_ready", {31'd0, bus.o_ready}, 32'd1);
    checkOutput("abort_valid", {31'd0, bus.o_valid}, 32'd0);
    checkOutput("abort_s",     {16'd0, bus.o_s},     32'd0);
    checkOutput("abort_c",     {31'd0, bus.o_c},     32'd0);
    checkOutput("abort_ovf",   {31'd0, bus.o_ovf},   32'd0);
    sb.delete();
    prev_s    = 16'h0000;
    saw_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.o_valid) saw_valid = 1'b1;
    end
    checkOutput("abort_no_valid", {31'd0, saw_valid}, 32'd0);
    runOp(16'hA5A5, 16'h5A5A, 1'b1, 1'b0);

    // A few random operations.
    for (int i = 0; i < 8; i++) begin
      runOp(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
